// File: rtl/dbg_scan_tx.sv
// dbg_scan_tx: host-side debug reader for the pipeline probe port.
// Drives the probe selectors, samples probe_data after a settle delay and
// ships each sample as a framed 8N1 UART byte stream on tx.
// Frame: {pc_flag, 2'b00, reg_idx}, data[15:8], data[7:0].
// Optional build macro DBG_SCAN_CHECKSUM_EN appends b3 = b0^b1^b2.
module dbg_scan_tx #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_REGS      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        single,
    input  logic        sel_pc,
    input  logic [4:0]  sel_reg,
    output logic [4:0]  probe_reg_num,
    output logic        probe_pc_or_not,
    input  logic [15:0] probe_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

`ifdef DBG_SCAN_CHECKSUM_EN
    localparam int NBYTES = 4;
`else
    localparam int NBYTES = 3;
`endif

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CW-1:0] BIT_LAST    = CW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [4:0]    REG_LAST    = 5'(NUM_REGS - 1);
    localparam logic [1:0]    BYTE_LAST   = 2'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE, SETTLE, LOAD, START, DATA, STOP, ADVANCE
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] settle_cnt, settle_cnt_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [1:0]    byte_idx, byte_idx_n;
    logic [15:0]   hold, hold_n;
    logic [7:0]    shreg, shreg_n;
    logic          single_q, single_q_n;
    logic [4:0]    reg_num_n;
    logic          pc_n;
    logic          tx_n, busy_n, done_n;
    logic [7:0]    header;
    logic          last_item;

    // Header byte; the register field is forced to zero for a PC item.
    assign header = {probe_pc_or_not, 2'b00, probe_pc_or_not ? 5'd0 : probe_reg_num};

    // The request ends after this item in single mode or after the last register.
    assign last_item = single_q || (!probe_pc_or_not && probe_reg_num == REG_LAST);

    function automatic logic [7:0] frame_byte(input logic [1:0]  idx,
                                              input logic [7:0]  hdr,
                                              input logic [15:0] d);
        case (idx)
            2'd0:    frame_byte = hdr;
            2'd1:    frame_byte = d[15:8];
            2'd2:    frame_byte = d[7:0];
`ifdef DBG_SCAN_CHECKSUM_EN
            default: frame_byte = hdr ^ d[15:8] ^ d[7:0];
`else
            default: frame_byte = 8'h00;
`endif
        endcase
    endfunction

    // State and datapath registers; outputs are registered so tx is glitch-free.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            bit_cnt         <= '0;
            bit_idx         <= '0;
            byte_idx        <= '0;
            hold            <= '0;
            shreg           <= '0;
            single_q        <= 1'b0;
            probe_reg_num   <= '0;
            probe_pc_or_not <= 1'b0;
            tx              <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state           <= state_n;
            settle_cnt      <= settle_cnt_n;
            bit_cnt         <= bit_cnt_n;
            bit_idx         <= bit_idx_n;
            byte_idx        <= byte_idx_n;
            hold            <= hold_n;
            shreg           <= shreg_n;
            single_q        <= single_q_n;
            probe_reg_num   <= reg_num_n;
            probe_pc_or_not <= pc_n;
            tx              <= tx_n;
            busy            <= busy_n;
            done            <= done_n;
        end
    end

    // Next-state, counter and next-output logic.
    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        bit_cnt_n    = bit_cnt;
        bit_idx_n    = bit_idx;
        byte_idx_n   = byte_idx;
        hold_n       = hold;
        shreg_n      = shreg;
        single_q_n   = single_q;
        reg_num_n    = probe_reg_num;
        pc_n         = probe_pc_or_not;

        case (state)
            IDLE: begin
                if (start) begin
                    single_q_n   = single;
                    pc_n         = single ? sel_pc : 1'b1;
                    reg_num_n    = (single && !sel_pc) ? sel_reg : 5'd0;
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_cnt_n = '0;
                    state_n      = LOAD;
                end else begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end
            end
            LOAD: begin
                hold_n     = probe_data;
                shreg_n    = header;
                byte_idx_n = '0;
                bit_cnt_n  = '0;
                state_n    = START;
            end
            START: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    bit_idx_n = '0;
                    state_n   = DATA;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    shreg_n   = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    if (byte_idx == BYTE_LAST) begin
                        state_n = ADVANCE;
                    end else begin
                        byte_idx_n = byte_idx + 1'b1;
                        shreg_n    = frame_byte(byte_idx + 2'd1, header, hold);
                        state_n    = START;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            ADVANCE: begin
                if (last_item) begin
                    state_n = IDLE;
                end else begin
                    if (probe_pc_or_not) begin
                        pc_n      = 1'b0;
                        reg_num_n = 5'd0;
                    end else begin
                        reg_num_n = probe_reg_num + 5'd1;
                    end
                    settle_cnt_n = '0;
                    state_n      = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Selectors do not change on STOP->ADVANCE, so last_item is valid here.
        done_n = (state_n == ADVANCE) && last_item;
        busy_n = (state_n != IDLE) && !done_n;
        if (state_n == START)
            tx_n = 1'b0;
        else if (state_n == DATA)
            tx_n = shreg_n[0];
        else
            tx_n = 1'b1;
    end

endmodule
